load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the execute stage and the word-organised data memory.
- Accepts one load/store request at a time over a valid/ready handshake. Computes byte enables and lane-shifts store data.
- Splits accesses that cross a word boundary into two memory cycles. Merges and sign/zero-extends load data.
- Returns a completion response to writeback over a second valid/ready handshake.
- The memory port is a single combinational-read, synchronous-write word port.

Parameters:
- ADDR_W, 12: byte-address width; word address is ADDR_W-2 bits.
- MISALIGN_SPLIT, 1: 1 = word-crossing accesses split into two cycles; 0 = they fault with no memory access.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  LSU can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I load/store funct3.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  32  store data, right-aligned.
- req_rd  in  5  load destination register.
- mem_addr  out  ADDR_W-2  word address.
- mem_be  out  4  byte-lane enables.
- mem_we  out  1  write strobe; memory commits enabled lanes at the next rising edge.
- mem_re  out  1  read strobe.
- mem_wdata  out  32  lane-aligned store data.
- mem_rdata  in  32  combinational read data for mem_addr.
- resp_valid  out  1  response present.
- resp_ready  in  1  writeback accepts.
- resp_data  out  32  extended load data; 0 for stores and faults.
- resp_rd  out  5  latched rd; 0 for stores and faults.
- resp_fault  out  1  misaligned (with split disabled) or illegal funct3.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- States: IDLE, ACC0, ACC1, RESP.
- Reset (any state, including mid-access):
  - state goes to IDLE and all request/response registers clear.
  - Outputs: req_ready=1; resp_valid=0, resp_data=0, resp_rd=0, resp_fault=0.
  - Memory port: mem_we=0, mem_re=0, mem_be=0, mem_addr=0, mem_wdata=0.
  - The pending request is dropped and no partial second access is issued.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch we, funct3, addr, wdata, rd.
  - Go to RESP with fault=1 if any of the following holds:
    - load funct3 is one of 3, 6, 7;
    - store funct3 > 2;
    - the access crosses a word and MISALIGN_SPLIT=0.
  - Otherwise go to ACC0.
- req_ready=0 in every state except IDLE.
- Size and lanes: n = 1/2/4 bytes for funct3[1:0] = 0/1/2; off = addr[1:0]. be8 = ((1<<n)-1) << off. The access crosses a word when be8[7:4] != 0.
- Store data: wd64 = {32'b0, wdata} << (8*off). First word uses wd64[31:0]; second word uses wd64[63:32].
- ACC0:
  - mem_addr = addr[ADDR_W-1:2], mem_be = be8[3:0], mem_we = we, mem_re = !we.
  - Loads register mem_rdata as lo.
  - Next state is ACC1 if the access crosses a word, else RESP.
- ACC1:
  - mem_addr = addr[ADDR_W-1:2]+1, wrapping modulo 2^(ADDR_W-2).
  - mem_be = be8[7:4], mem_wdata = wd64[63:32]. Loads register mem_rdata as hi.
  - Next state is RESP.
- Load extension: rd64 = {hi, lo} >> (8*off); take the low n bytes. Sign-extend if funct3[2]=0, zero-extend if 1; lw ignores funct3[2]. Result is registered into resp_data on entry to RESP.
- RESP:
  - resp_valid=1; all response outputs are held stable while resp_ready=0.
  - On resp_ready, go to IDLE and drop resp_valid the next cycle.
  - No new request is accepted in the same cycle.
- Memory port outside ACC0/ACC1: all outputs are 0, so the memory never sees a stray write.
- Latency, accept edge to resp_valid: aligned 2 cycles; split 3 cycles; fault 1 cycle.
- Throughput: one request per 3 cycles (aligned), with resp_ready held high.
- Store faults leave memory untouched.

Decomposition:
- Package rv_mem_pkg holds:
  - funct3 constants F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5;
  - lsu_state_t enum {IDLE, ACC0, ACC1, RESP};
  - a size-decode function.
- Sub-module lsu_align (combinational) holds be8 generation, wd64 shift, and the rd64 shift/extend.
- load_store_unit keeps the FSM, latches and both handshakes.

Test Plan:
- Aligned store/load word:
  - sw 0xDEADBEEF at 0x010 -> one ACC0 cycle with mem_addr=4, mem_be=1111.
  - lw 0x010 -> resp_data=0xDEADBEEF, resp_valid 2 cycles after accept.
- Byte and half loads:
  - Memory word 4 = 0x80FF7F01.
  - lb 0x013 -> 0xFFFFFF80; lbu 0x013 -> 0x00000080.
  - lh 0x012 -> 0xFFFF80FF; lhu 0x012 -> 0x000080FF.
- Split, MISALIGN_SPLIT=1:
  - sw 0x11223344 at 0x013 -> ACC0 addr=4, be=1000, wdata=0x44000000; then ACC1 addr=5, be=0111, wdata=0x00112233.
  - lw 0x013 -> 0x11223344 after 3 cycles.
- Wrap and fault:
  - lh at 0xFFF -> second access at mem_addr=0, be=0001.
  - With MISALIGN_SPLIT=0, lw 0x011 -> resp_fault=1, resp_data=0, no mem_re/mem_we.
- Backpressure: hold resp_ready=0 for 5 cycles -> resp_* stable, req_ready=0, mem_* all zero; release -> IDLE next cycle.
- Reset mid-split: assert rst during ACC0 of a split sw -> mem_we=0 immediately; ACC1 is never issued; the word at mem_addr+1 is unchanged; req_ready=1.

Source files
------------

// File: rtl/rv_mem_pkg.sv
// Shared RV32I load/store definitions: funct3 codes, LSU state encoding and size decode.
package rv_mem_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} lsu_state_t;

   // Access size in bytes from funct3[1:0]; the reserved size code is rejected elsewhere.
   function automatic logic [2:0] access_bytes(input logic [1:0] sizeCode);
      case (sizeCode)
         2'd0:    return 3'd1;
         2'd1:    return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment for the LSU: byte enables over two words, store-data shift,
// and load-data merge with sign/zero extension.
module lsu_align
   import rv_mem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] lo,
   input  logic [31:0] hi,
   output logic [7:0]  be8,
   output logic [63:0] wd64,
   output logic [31:0] rdataExt,
   output logic        crosses
);

   logic [2:0]  nBytes;
   logic [3:0]  laneMask;
   logic [31:0] rdLow;
   logic        signExt;

   always_comb begin
      nBytes   = access_bytes(funct3[1:0]);
      laneMask = 4'((5'd1 << nBytes) - 5'd1);
      be8      = {4'b0000, laneMask} << off;
      crosses  = |be8[7:4];
      wd64     = {32'b0, wdata} << {off, 3'b000};
      rdLow    = 32'({hi, lo} >> {off, 3'b000});
      signExt  = !funct3[2];
      // Word loads pass straight through, so funct3[2] has no effect on them.
      case (nBytes)
         3'd1:    rdataExt = {{24{signExt & rdLow[7]}}, rdLow[7:0]};
         3'd2:    rdataExt = {{16{signExt & rdLow[15]}}, rdLow[15:0]};
         default: rdataExt = rdLow;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-wide data memory; word-crossing
// accesses are either split into two memory cycles or faulted.
module load_store_unit
   import rv_mem_pkg::*;
#(
   parameter int ADDR_W         = 12,
   parameter bit MISALIGN_SPLIT = 1'b1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [4:0]        req_rd,
   output logic [ADDR_W-3:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic              mem_we,
   output logic              mem_re,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_data,
   output logic [4:0]        resp_rd,
   output logic              resp_fault
);

   localparam int WA = ADDR_W - 2;

   lsu_state_t        state, nextState;
   logic              weQ;
   logic [2:0]        funct3Q;
   logic [ADDR_W-1:0] addrQ;
   logic [31:0]       wdataQ, loQ, respDataQ;
   logic [4:0]        rdQ, respRdQ;
   logic              respFaultQ;

   logic [2:0]  alignFunct3;
   logic [1:0]  alignOff;
   logic [31:0] alignLo, rdataExt;
   logic [7:0]  be8;
   logic [63:0] wd64;
   logic        crosses, accept, illegal, fault;

   // In IDLE the aligner looks at the incoming request so the fault decision is made at accept.
   assign alignFunct3 = (state == IDLE) ? req_funct3 : funct3Q;
   assign alignOff    = (state == IDLE) ? req_addr[1:0] : addrQ[1:0];
   assign alignLo     = (state == ACC0) ? mem_rdata : loQ;

   lsu_align u_align (
      .funct3   (alignFunct3),
      .off      (alignOff),
      .wdata    (wdataQ),
      .lo       (alignLo),
      .hi       (mem_rdata),
      .be8      (be8),
      .wd64     (wd64),
      .rdataExt (rdataExt),
      .crosses  (crosses)
   );

   assign accept  = req_valid && req_ready;
   assign illegal = req_we ? (req_funct3 > F3_W)
                           : ((req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11));
   assign fault   = illegal || (crosses && !MISALIGN_SPLIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (accept) nextState = fault ? RESP : ACC0;
         ACC0:    nextState = crosses ? ACC1 : RESP;
         ACC1:    nextState = RESP;
         RESP:    if (resp_ready) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // The memory port is driven only during ACC0/ACC1, so it sees nothing between accesses.
   always_comb begin
      req_ready  = (state == IDLE);
      resp_valid = (state == RESP);
      mem_addr   = '0;
      mem_be     = '0;
      mem_we     = 1'b0;
      mem_re     = 1'b0;
      mem_wdata  = '0;
      case (state)
         ACC0: begin
            mem_addr  = addrQ[ADDR_W-1:2];
            mem_be    = be8[3:0];
            mem_we    = weQ;
            mem_re    = !weQ;
            mem_wdata = wd64[31:0];
         end
         ACC1: begin
            mem_addr  = addrQ[ADDR_W-1:2] + WA'(1);
            mem_be    = be8[7:4];
            mem_we    = weQ;
            mem_re    = !weQ;
            mem_wdata = wd64[63:32];
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         weQ        <= 1'b0;
         funct3Q    <= '0;
         addrQ      <= '0;
         wdataQ     <= '0;
         rdQ        <= '0;
         loQ        <= '0;
         respDataQ  <= '0;
         respRdQ    <= '0;
         respFaultQ <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               weQ        <= req_we;
               funct3Q    <= req_funct3;
               addrQ      <= req_addr;
               wdataQ     <= req_wdata;
               rdQ        <= req_rd;
               respFaultQ <= fault;
               respDataQ  <= '0;
               respRdQ    <= '0;
            end
            ACC0: begin
               loQ <= mem_rdata;
               if (!crosses) begin
                  respDataQ <= weQ ? '0 : rdataExt;
                  respRdQ   <= weQ ? '0 : rdQ;
               end
            end
            ACC1: begin
               respDataQ <= weQ ? '0 : rdataExt;
               respRdQ   <= weQ ? '0 : rdQ;
            end
            default: ;
         endcase
      end
   end

   assign resp_data  = respDataQ;
   assign resp_rd    = respRdQ;
   assign resp_fault = respFaultQ;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a split-enabled instance backed by a word
// memory and a byte-level reference model, plus a fault-on-misalign instance.
module tb_load_store_unit;
   import rv_mem_pkg::*;

   localparam logic [31:0] NS_WORD = 32'h80FF7F01;

   logic        clk = 1'b0;
   logic        rst, memLoad, selNs;
   logic        reqValid, reqWe, respReady;
   logic [2:0]  reqFunct3;
   logic [11:0] reqAddr;
   logic [31:0] reqWdata;
   logic [4:0]  reqRd;

   logic        reqReadyS, memWeS, memReS, respValidS, respFaultS;
   logic [9:0]  memAddrS;
   logic [3:0]  memBeS;
   logic [31:0] memWdataS, memRdataS, respDataS;
   logic [4:0]  respRdS;

   logic        reqReadyN, memWeN, memReN, respValidN, respFaultN;
   logic [9:0]  memAddrN;
   logic [3:0]  memBeN;
   logic [31:0] memWdataN, respDataN;
   logic [4:0]  respRdN;

   logic        vReqReady, vMemWe, vMemRe, vRespValid, vRespFault;
   logic [9:0]  vMemAddr;
   logic [3:0]  vMemBe;
   logic [31:0] vMemWdata, vRespData;
   logic [4:0]  vRespRd;

   logic [7:0]  refMem [0:4095];
   logic [31:0] mem [0:1023];

   int          testsRun = 0;
   int          testsFailed = 0;
   int          nAcc, latency;
   logic [9:0]  accAddr [2];
   logic [3:0]  accBe [2];
   logic [31:0] accWd [2];
   logic        accWe [2];
   logic        accRe [2];
   logic [31:0] gotData;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_W(12), .MISALIGN_SPLIT(1'b1)) dutSplit (
      .clk(clk), .rst(rst), .req_valid(reqValid & !selNs), .req_ready(reqReadyS),
      .req_we(reqWe), .req_funct3(reqFunct3), .req_addr(reqAddr), .req_wdata(reqWdata),
      .req_rd(reqRd), .mem_addr(memAddrS), .mem_be(memBeS), .mem_we(memWeS),
      .mem_re(memReS), .mem_wdata(memWdataS), .mem_rdata(memRdataS),
      .resp_valid(respValidS), .resp_ready(respReady), .resp_data(respDataS),
      .resp_rd(respRdS), .resp_fault(respFaultS)
   );

   load_store_unit #(.ADDR_W(12), .MISALIGN_SPLIT(1'b0)) dutNoSplit (
      .clk(clk), .rst(rst), .req_valid(reqValid & selNs), .req_ready(reqReadyN),
      .req_we(reqWe), .req_funct3(reqFunct3), .req_addr(reqAddr), .req_wdata(reqWdata),
      .req_rd(reqRd), .mem_addr(memAddrN), .mem_be(memBeN), .mem_we(memWeN),
      .mem_re(memReN), .mem_wdata(memWdataN), .mem_rdata(NS_WORD),
      .resp_valid(respValidN), .resp_ready(respReady), .resp_data(respDataN),
      .resp_rd(respRdN), .resp_fault(respFaultN)
   );

   assign vReqReady  = selNs ? reqReadyN  : reqReadyS;
   assign vMemWe     = selNs ? memWeN     : memWeS;
   assign vMemRe     = selNs ? memReN     : memReS;
   assign vMemAddr   = selNs ? memAddrN   : memAddrS;
   assign vMemBe     = selNs ? memBeN     : memBeS;
   assign vMemWdata  = selNs ? memWdataN  : memWdataS;
   assign vRespValid = selNs ? respValidN : respValidS;
   assign vRespData  = selNs ? respDataN  : respDataS;
   assign vRespRd    = selNs ? respRdN    : respRdS;
   assign vRespFault = selNs ? respFaultN : respFaultS;

   // Word memory for the split instance: combinational read, lane-masked write at the rising edge.
   assign memRdataS = mem[memAddrS];
   always @(posedge clk) begin
      if (memLoad) begin
         for (int w = 0; w < 1024; w++)
            mem[w] <= {refMem[4*w+3], refMem[4*w+2], refMem[4*w+1], refMem[4*w]};
      end else if (memWeS) begin
         for (int b = 0; b < 4; b++)
            if (memBeS[b]) mem[memAddrS][8*b +: 8] <= memWdataS[8*b +: 8];
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Byte-level reference: enables, fault decision, access count and load result from the rules.
   task automatic refModel(input logic we, input logic [2:0] f3, input logic [11:0] addr,
                           input logic [31:0] wd, input logic [4:0] rd,
                           output logic [31:0] eData, output logic [4:0] eRd, output logic eFault,
                           output int eAcc, output logic [3:0] eBe0, output logic [3:0] eBe1);
      int n, off;
      logic illegal;
      logic [31:0] val;
      n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      off = int'(addr % 4);
      illegal = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
      eBe0 = 4'b0;
      eBe1 = 4'b0;
      for (int i = 0; i < n; i++)
         if (off + i < 4) eBe0[off+i] = 1'b1;
         else             eBe1[off+i-4] = 1'b1;
      eFault = illegal;
      eAcc = eFault ? 0 : ((eBe1 != 4'b0) ? 2 : 1);
      eData = '0;
      eRd = '0;
      if (eFault) return;
      if (we) begin
         for (int i = 0; i < n; i++) refMem[(int'(addr) + i) % 4096] = wd[8*i +: 8];
      end else begin
         val = '0;
         for (int i = 0; i < n; i++) val[8*i +: 8] = refMem[(int'(addr) + i) % 4096];
         if (n < 4 && !f3[2] && val[8*n-1])
            for (int i = 8*n; i < 32; i++) val[i] = 1'b1;
         eData = val;
         eRd = rd;
      end
   endtask

   // One full transaction on the selected instance, with optional response backpressure.
   task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [11:0] addr,
                                input logic [31:0] wd, input logic [4:0] rd, input int stall,
                                input logic [31:0] eData, input logic [4:0] eRd, input logic eFault);
      @(negedge clk);
      checkOutput("req_ready_idle", 32'(vReqReady), 32'd1);
      reqValid = 1'b1; reqWe = we; reqFunct3 = f3; reqAddr = addr; reqWdata = wd; reqRd = rd;
      respReady = (stall == 0);
      @(negedge clk);
      reqValid = 1'b0;
      nAcc = 0;
      latency = 1;
      while (!vRespValid && latency < 8) begin
         if (vMemRe || vMemWe) begin
            if (nAcc < 2) begin
               accAddr[nAcc] = vMemAddr; accBe[nAcc] = vMemBe; accWd[nAcc] = vMemWdata;
               accWe[nAcc] = vMemWe; accRe[nAcc] = vMemRe;
            end
            nAcc++;
         end
         @(negedge clk);
         latency++;
      end
      if (!vRespValid) checkOutput("resp_timeout", 32'd0, 32'd1);
      gotData = vRespData;
      checkOutput("resp_data", vRespData, eData);
      checkOutput("resp_rd", 32'(vRespRd), 32'(eRd));
      checkOutput("resp_fault", 32'(vRespFault), 32'(eFault));
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         checkOutput("hold_valid", 32'(vRespValid), 32'd1);
         checkOutput("hold_data", vRespData, eData);
         checkOutput("hold_req_ready", 32'(vReqReady), 32'd0);
         checkOutput("hold_mem_quiet",
                     32'(vMemAddr) | vMemWdata | {26'b0, vMemWe, vMemRe, vMemBe}, 32'd0);
      end
      respReady = 1'b1;
      @(negedge clk);
      checkOutput("resp_dropped", 32'(vRespValid), 32'd0);
      checkOutput("ready_back", 32'(vReqReady), 32'd1);
   endtask

   task automatic runTxn(input logic we, input logic [2:0] f3, input logic [11:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd, input int stall);
      logic [31:0] eData;
      logic [4:0]  eRd;
      logic        eFault;
      int          eAcc;
      logic [3:0]  eBe0, eBe1;
      refModel(we, f3, addr, wd, rd, eData, eRd, eFault, eAcc, eBe0, eBe1);
      applyStimulus(we, f3, addr, wd, rd, stall, eData, eRd, eFault);
      checkOutput("latency", 32'(latency), 32'(eAcc + 1));
      checkOutput("mem_accesses", 32'(nAcc), 32'(eAcc));
      if (eAcc > 0) begin
         checkOutput("acc0_addr", 32'(accAddr[0]), 32'(addr >> 2));
         checkOutput("acc0_be", 32'(accBe[0]), 32'(eBe0));
         checkOutput("acc0_strobe", 32'({accWe[0], accRe[0]}), we ? 32'd2 : 32'd1);
      end
      if (eAcc > 1) begin
         checkOutput("acc1_addr", 32'(accAddr[1]), 32'(((int'(addr) >> 2) + 1) % 1024));
         checkOutput("acc1_be", 32'(accBe[1]), 32'(eBe1));
      end
   endtask

   initial begin
      int stray, badWords, lf;
      logic [2:0] f3;
      logic [11:0] addr;
      logic we;

      for (int i = 0; i < 4096; i++) refMem[i] = 8'($urandom);
      rst = 1'b1; memLoad = 1'b1; selNs = 1'b0;
      reqValid = 1'b0; reqWe = 1'b0; reqFunct3 = '0; reqAddr = '0; reqWdata = '0; reqRd = '0;
      respReady = 1'b1;
      repeat (3) @(negedge clk);
      memLoad = 1'b0;
      checkOutput("rst_req_ready", 32'(vReqReady), 32'd1);
      checkOutput("rst_resp_valid", 32'(vRespValid), 32'd0);
      checkOutput("rst_resp_bus", vRespData | 32'(vRespRd) | 32'(vRespFault), 32'd0);
      checkOutput("rst_mem_quiet", 32'(vMemAddr) | vMemWdata | {26'b0, vMemWe, vMemRe, vMemBe}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      runTxn(1'b1, F3_W, 12'h010, 32'hDEADBEEF, 5'd0, 0);
      checkOutput("sw_addr", 32'(accAddr[0]), 32'd4);
      checkOutput("sw_be", 32'(accBe[0]), 32'hF);
      checkOutput("sw_wdata", accWd[0], 32'hDEADBEEF);
      runTxn(1'b0, F3_W, 12'h010, 32'h0, 5'd3, 0);
      checkOutput("lw_value", gotData, 32'hDEADBEEF);

      runTxn(1'b1, F3_W, 12'h010, 32'h80FF7F01, 5'd0, 0);
      runTxn(1'b0, F3_B, 12'h013, 32'h0, 5'd4, 0);
      checkOutput("lb_value", gotData, 32'hFFFFFF80);
      runTxn(1'b0, F3_BU, 12'h013, 32'h0, 5'd5, 0);
      checkOutput("lbu_value", gotData, 32'h00000080);
      runTxn(1'b0, F3_H, 12'h012, 32'h0, 5'd6, 0);
      checkOutput("lh_value", gotData, 32'hFFFF80FF);
      runTxn(1'b0, F3_HU, 12'h012, 32'h0, 5'd7, 0);
      checkOutput("lhu_value", gotData, 32'h000080FF);

      runTxn(1'b1, F3_W, 12'h013, 32'h11223344, 5'd0, 0);
      checkOutput("split_acc0", {22'b0, accAddr[0]} | {accBe[0], 28'b0}, {4'h8, 28'd4});
      checkOutput("split_wd0", accWd[0], 32'h44000000);
      checkOutput("split_acc1", {22'b0, accAddr[1]} | {accBe[1], 28'b0}, {4'h7, 28'd5});
      checkOutput("split_wd1", accWd[1], 32'h00112233);
      runTxn(1'b0, F3_W, 12'h013, 32'h0, 5'd8, 0);
      checkOutput("split_lw_value", gotData, 32'h11223344);
      checkOutput("split_lw_latency", 32'(latency), 32'd3);

      runTxn(1'b0, F3_H, 12'hFFF, 32'h0, 5'd9, 0);
      checkOutput("wrap_addr", 32'(accAddr[1]), 32'd0);
      checkOutput("wrap_be", 32'(accBe[1]), 32'h1);
      runTxn(1'b0, 3'd3, 12'h020, 32'h0, 5'd10, 0);
      runTxn(1'b1, 3'd5, 12'h020, 32'h12345678, 5'd0, 0);
      runTxn(1'b0, F3_W, 12'h010, 32'h0, 5'd11, 5);

      // Reset in the first half of a split store: no write may land in either word.
      @(negedge clk);
      reqValid = 1'b1; reqWe = 1'b1; reqFunct3 = F3_W; reqAddr = 12'h017;
      reqWdata = 32'hCAFEF00D; reqRd = 5'd0; respReady = 1'b1;
      @(negedge clk);
      reqValid = 1'b0;
      checkOutput("mid_acc0_we", 32'(vMemWe), 32'd1);
      #2 rst = 1'b1;
      #1;
      checkOutput("mid_rst_we", 32'(vMemWe), 32'd0);
      checkOutput("mid_rst_be", 32'(vMemBe), 32'd0);
      checkOutput("mid_rst_ready", 32'(vReqReady), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      stray = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (vMemWe || vMemRe) stray++;
      end
      checkOutput("mid_no_acc1", 32'(stray), 32'd0);
      checkOutput("mid_word5", mem[5], {refMem[23], refMem[22], refMem[21], refMem[20]});
      checkOutput("mid_word6", mem[6], {refMem[27], refMem[26], refMem[25], refMem[24]});

      selNs = 1'b1;
      applyStimulus(1'b0, F3_W, 12'h011, 32'h0, 5'd12, 0, 32'h0, 5'd0, 1'b1);
      checkOutput("ns_fault_latency", 32'(latency), 32'd1);
      checkOutput("ns_fault_no_mem", 32'(nAcc), 32'd0);
      applyStimulus(1'b0, F3_H, 12'h013, 32'h0, 5'd13, 0, 32'h0, 5'd0, 1'b1);
      checkOutput("ns_lh_no_mem", 32'(nAcc), 32'd0);
      applyStimulus(1'b0, F3_W, 12'h010, 32'h0, 5'd14, 0, NS_WORD, 5'd14, 1'b0);
      checkOutput("ns_lw_latency", 32'(latency), 32'd2);
      applyStimulus(1'b0, F3_H, 12'h012, 32'h0, 5'd15, 0, 32'hFFFF80FF, 5'd15, 1'b0);
      applyStimulus(1'b0, F3_BU, 12'h011, 32'h0, 5'd16, 0, 32'h0000007F, 5'd16, 1'b0);
      applyStimulus(1'b1, F3_B, 12'h013, 32'h000000AB, 5'd17, 0, 32'h0, 5'd0, 1'b0);
      checkOutput("ns_sb_be", 32'(accBe[0]), 32'h8);
      checkOutput("ns_sb_wdata", accWd[0], 32'hAB000000);
      selNs = 1'b0;

      for (int t = 0; t < 200; t++) begin
         we = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) < 14) begin
            lf = int'($urandom_range(0, 4));
            f3 = we ? 3'(lf % 3) : 3'((lf > 2) ? lf + 1 : lf);
         end else begin
            f3 = we ? 3'($urandom_range(3, 7)) : (($urandom_range(0, 2) == 0) ? 3'd3 : 3'($urandom_range(6, 7)));
         end
         addr = 12'($urandom_range(0, 63));
         if ($urandom_range(0, 7) == 0) addr = 12'hFF8 + 12'($urandom_range(0, 7));
         runTxn(we, f3, addr, $urandom, 5'($urandom_range(0, 31)), int'($urandom_range(0, 2)));
      end

      @(negedge clk);
      badWords = 0;
      for (int w = 0; w < 1024; w++)
         if (mem[w] !== {refMem[4*w+3], refMem[4*w+2], refMem[4*w+1], refMem[4*w]}) badWords++;
      checkOutput("memory_image", 32'(badWords), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got no finish expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
